// File: rtl/pwm_generator.sv
// pwm_generator
//   Sixteen-channel PWM driver sharing one duty value. A prescaler divides clk
//   into count steps; an 8-bit step counter runs 0..254, so one PWM period is
//   255*PRESCALE clk cycles. The duty value is shadowed and only reloaded at
//   the period boundary, which keeps every period glitch-free.
//
// Parameters
//   PRESCALE      clk cycles per PWM count step (1..65535)
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   en_out[15:0]  per-output enable; 0 forces that output low
//   pwm_sel[15:0] per-output mode; 1 = PWM level, 0 = static high when enabled
//   duty[7:0]     shared duty value (high steps per period)
//   out[15:0]     registered drive outputs
//   period_start  registered one-cycle pulse on the first out cycle of a period
module pwm_generator #(
    parameter int unsigned PRESCALE = 39
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] en_out,
    input  logic [15:0] pwm_sel,
    input  logic [7:0]  duty,
    output logic [15:0] out,
    output logic        period_start
);

    // PRESCALE=1 would give a zero-width counter; keep at least one bit.
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [7:0]       STEP_MAX = 8'd254;

    logic [PRE_W-1:0] pre_cnt;
    logic [7:0]       step_cnt;
    logic [7:0]       duty_q;
    logic             tick;
    logic             level;
    logic             boundary;
    logic [15:0]      out_next;

    always_comb begin
        tick     = (pre_cnt == PRE_MAX);
        boundary = tick && (step_cnt == STEP_MAX);
        // duty_q = 0xFF never reaches full-high by itself through step < 255
        // only because step_cnt tops out at 254, so 0xFF is 100% by range.
        level    = (step_cnt < duty_q);
        // Enabled PWM channels take the shared level, enabled static channels
        // are high, disabled channels are low.
        out_next = en_out & (~pwm_sel | {16{level}});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt      <= '0;
            step_cnt     <= '0;
            duty_q       <= '0;
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;

            if (tick) begin
                step_cnt <= (step_cnt == STEP_MAX) ? '0 : step_cnt + 8'd1;
            end

            // Loading on the same edge that wraps step_cnt to 0 means the new
            // duty is in effect from the first cycle of the next period.
            if (boundary) begin
                duty_q <= duty;
            end

            out          <= out_next;
            period_start <= (step_cnt == 8'd0) && (pre_cnt == '0);
        end
    end

endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 SHALL have parameter PRESCALE, default 39, meaning clk cycles per PWM count step (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port en_out  input  16  per-output enable; 0 forces the output low.
REQ-005 SHALL have port pwm_sel  input  16  per-output mode; 1 = PWM, 0 = static high when enabled.
REQ-006 SHALL have port duty  input  8  shared duty value; high steps per period.
REQ-007 SHALL have port out  output  16  registered drive outputs.
REQ-008 SHALL have port period_start  output  1  registered one-cycle pulse marking the first cycle of each PWM period.

Function
REQ-009 SHALL contain a prescaler pre_cnt with range 0..PRESCALE-1, incrementing every clk and wrapping to 0 after PRESCALE-1.
REQ-010 SHALL assert internal tick in cycles where pre_cnt == PRESCALE-1; with PRESCALE=1, tick SHALL be high every cycle.
REQ-011 SHALL contain an 8-bit step counter step_cnt with range 0..254 that advances only on tick and wraps 254 -> 0, giving a period of 255*PRESCALE clk cycles.
REQ-012 SHALL hold a shadow register duty_q; PWM level SHALL be (step_cnt < duty_q), unsigned 8-bit compare.
REQ-013 SHALL load duty_q from duty only on the edge where tick is high and step_cnt == 254, i.e. at the period boundary.
REQ-014 SHALL ignore duty changes mid-period; the new value SHALL take effect from the next period's first cycle.
REQ-015 SHALL produce 0% duty (level always low) for duty_q = 0x00, and 100% duty (level always high) for duty_q = 0xFF.
REQ-016 SHALL register out[i] = en_out[i] ? (pwm_sel[i] ? level : 1) : 0, evaluated from the current-cycle state, giving exactly one clk cycle of latency.
REQ-017 SHALL sample en_out and pwm_sel every cycle without shadowing; a change SHALL be visible on out one cycle later, even mid-period.
REQ-018 SHALL register period_start high for exactly one cycle, in the cycle after step_cnt == 0 and pre_cnt == 0, aligned with the first out cycle of that period.
REQ-019 SHALL drive all 16 outputs in PWM mode from the same level, so they are phase-aligned and edge-synchronous.
REQ-020 SHALL keep pre_cnt wide enough for PRESCALE-1 with no overflow at the maximum legal PRESCALE.

Reset
REQ-021 SHALL, while rst_n is low at a clk edge, clear pre_cnt, step_cnt and duty_q to 0, and out and period_start to 0.
REQ-022 SHALL, because duty_q resets to 0, hold PWM-mode outputs low for the whole first period after reset; static-mode outputs SHALL follow REQ-016 from the first cycle.
REQ-023 SHALL abandon any in-progress period when reset is asserted mid-operation; the next period SHALL start from step 0 with duty_q = 0.
REQ-024 SHALL start counting on the first edge with rst_n high; the first period_start pulse SHALL appear 2 cycles after reset release.

Verification (PRESCALE=2, period = 510 cycles)
REQ-025 SHALL cover: en_out=0xFFFF, pwm_sel=0x0000 after reset -> out=0xFFFF from cycle 2 onward, never toggling.
REQ-026 SHALL cover: en_out=0x0001, pwm_sel=0x0001, duty=0x80 held -> period 1 all low; every later period has out[0] high for 256 cycles and low for 254 cycles, and out[15:1]=0.
REQ-027 SHALL cover: duty=0x00 then 0xFF, each held for 2 periods -> out[0] constantly low, then constantly high with no glitch at period boundaries.
REQ-028 SHALL cover: duty changed 0x40 -> 0xC0 at step 100 -> the current period keeps a 128-cycle high time; the next period has a 384-cycle high time, starting with period_start.
REQ-029 SHALL cover: en_out[3] toggled mid-period, pwm_sel[3]=1 -> out[3] follows within 1 cycle; the period_start spacing stays 510 cycles.
REQ-030 SHALL cover: rst_n low for 3 cycles at step 200 -> out=0 during reset; after release, the first period is all low and period_start occurs 2 cycles after release.
